// File: rtl/trace_trigger_scheduler.sv
// rtl/trace_trigger_scheduler.sv - trace hit capture, round-robin sniff-FIFO logging and trigger FSM
// Optional trigger holdoff (trig_holdoff port) is built when TRACE_TRIG_HOLDOFF_EN is defined.
`timescale 1ns/1ps

module trace_trigger_scheduler #(
    parameter int pNUM_RULES      = 8,
    parameter int pTS_WIDTH       = 56,
    parameter int pTRIG_PULSE_LEN = 4
) (
    input  logic                    trace_clk,
    input  logic                    resetn,
    input  logic [pNUM_RULES-1:0]   match_hit,
    input  logic [pNUM_RULES-1:0]   pattern_enable,
    input  logic                    trig_enable,
    input  logic                    trig_toggle,
    input  logic                    ts_clear,
    input  logic                    fifo_full,
    input  logic                    overflow_clear,
`ifdef TRACE_TRIG_HOLDOFF_EN
    input  logic [15:0]             trig_holdoff,
`endif
    output logic                    fifo_wr_en,
    output logic [8+pTS_WIDTH-1:0]  fifo_wr_data,
    output logic                    trig_out,
    output logic [pNUM_RULES-1:0]   pending,
    output logic                    overflow
);

    localparam int IDX_W = (pNUM_RULES > 1) ? $clog2(pNUM_RULES) : 1;
    localparam int CNT_W = (pTRIG_PULSE_LEN > 1) ? $clog2(pTRIG_PULSE_LEN) : 1;
    localparam logic [IDX_W:0]   RULES_CNT = (IDX_W+1)'(pNUM_RULES);
    localparam logic [IDX_W-1:0] LAST_RULE = IDX_W'(pNUM_RULES - 1);
    localparam logic [CNT_W-1:0] PULSE_RELOAD = CNT_W'(pTRIG_PULSE_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PULSE  = 2'd1,
        ST_TOGGLE = 2'd2
    } trig_state_t;

    logic [pTS_WIDTH-1:0]    ts_q, ts_d;
    logic [pTS_WIDTH-1:0]    ts_reg_q [pNUM_RULES];
    logic [pNUM_RULES-1:0]   pending_q, pending_d;
    logic [pNUM_RULES-1:0]   hit_v, grant_oh;
    logic [IDX_W-1:0]        rr_q, rr_d, grant_idx;
    logic [IDX_W:0]          scan_idx;
    logic                    grant_valid;
    logic                    ovf_q, ovf_d, ovf_evt;
    logic                    wr_en_q;
    logic [8+pTS_WIDTH-1:0]  wr_data_q, wr_data_d;

    trig_state_t             state_q, state_d;
    logic                    trig_q, trig_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    toggle_q;
    logic                    mode_change, any_hit, trig_evt;

    // Round-robin scan starting at rr_q; the first pending rule found wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < pNUM_RULES; k++) begin
            scan_idx = {1'b0, rr_q} + (IDX_W+1)'(k);
            if (scan_idx >= RULES_CNT) begin
                scan_idx = scan_idx - RULES_CNT;
            end
            if (!grant_valid && pending_q[scan_idx[IDX_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx[IDX_W-1:0];
            end
        end
        if (fifo_full) begin
            grant_valid = 1'b0;
        end
    end

    always_comb begin
        hit_v    = match_hit & pattern_enable;
        grant_oh = '0;
        for (int i = 0; i < pNUM_RULES; i++) begin
            grant_oh[i] = grant_valid && (grant_idx == IDX_W'(i));
        end
        // A granted rule frees its slot this cycle, so a same-cycle re-hit is kept, not dropped.
        pending_d = (pending_q & ~grant_oh) | hit_v;
        ovf_evt   = |(hit_v & pending_q & ~grant_oh);
        ovf_d     = (ovf_q & ~overflow_clear) | ovf_evt;
        ts_d      = ts_clear ? '0 : ts_q + 1'b1;
        rr_d      = rr_q;
        wr_data_d = wr_data_q;
        if (grant_valid) begin
            rr_d      = (grant_idx == LAST_RULE) ? '0 : grant_idx + 1'b1;
            wr_data_d = {8'(grant_idx), ts_reg_q[grant_idx]};
        end
    end

    assign any_hit     = |hit_v;
    assign mode_change = (trig_toggle != toggle_q);

`ifdef TRACE_TRIG_HOLDOFF_EN
    logic [15:0] hold_q, hold_d;

    always_comb begin
        hold_d = hold_q;
        if (!trig_enable) begin
            hold_d = '0;
        end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end else if (any_hit && !mode_change) begin
            hold_d = trig_holdoff;
        end
    end

    assign trig_evt = any_hit && (hold_q == '0);

    always_ff @(posedge trace_clk) begin
        if (!resetn) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign trig_evt = any_hit;
`endif

    always_comb begin
        state_d = state_q;
        trig_d  = trig_q;
        cnt_d   = cnt_q;
        if (!trig_enable || mode_change) begin
            state_d = ST_IDLE;
            trig_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trig_evt) begin
                        trig_d = 1'b1;
                        if (trig_toggle) begin
                            state_d = ST_TOGGLE;
                        end else begin
                            state_d = ST_PULSE;
                            cnt_d   = PULSE_RELOAD;
                        end
                    end
                end
                ST_PULSE: begin
                    if (trig_evt) begin
                        trig_d = 1'b1;
                        cnt_d  = PULSE_RELOAD;
                    end else if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                        trig_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_TOGGLE: begin
                    if (trig_evt) begin
                        trig_d = ~trig_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    trig_d  = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge trace_clk) begin
        if (!resetn) begin
            ts_q      <= '0;
            pending_q <= '0;
            rr_q      <= '0;
            ovf_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            state_q   <= ST_IDLE;
            trig_q    <= 1'b0;
            cnt_q     <= '0;
            toggle_q  <= trig_toggle;
            for (int i = 0; i < pNUM_RULES; i++) begin
                ts_reg_q[i] <= '0;
            end
        end else begin
            ts_q      <= ts_d;
            pending_q <= pending_d;
            rr_q      <= rr_d;
            ovf_q     <= ovf_d;
            wr_en_q   <= grant_valid;
            wr_data_q <= wr_data_d;
            state_q   <= state_d;
            trig_q    <= trig_d;
            cnt_q     <= cnt_d;
            toggle_q  <= trig_toggle;
            for (int i = 0; i < pNUM_RULES; i++) begin
                if (hit_v[i] && (!pending_q[i] || grant_oh[i])) begin
                    ts_reg_q[i] <= ts_q;
                end
            end
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign trig_out     = trig_q;
    assign pending      = pending_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_trace_trigger_scheduler.sv
// tb/tb_trace_trigger_scheduler.sv - self-checking bench for trace_trigger_scheduler
`timescale 1ns/1ps

module tb_trace_trigger_scheduler;

    typedef struct {
        logic [7:0] hit;
        logic [7:0] en;
        logic [7:0] exp_pend;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  match_hit;
    logic [7:0]  pattern_enable;
    logic        trig_enable;
    logic        trig_toggle;
    logic        ts_clear;
    logic        fifo_full;
    logic        overflow_clear;
    logic        fifo_wr_en;
    logic [63:0] fifo_wr_data;
    logic        trig_out;
    logic [7:0]  pending;
    logic        overflow;
`ifdef TRACE_TRIG_HOLDOFF_EN
    logic [15:0] trig_holdoff;
`endif

    int          tests = 0;
    int          fails = 0;
    int          tb_rr = 0;
    logic [55:0] tb_ts = '0;
    logic [63:0] sb[$];
    vec_t        vecs[8];

    trace_trigger_scheduler #(
        .pNUM_RULES      (8),
        .pTS_WIDTH       (56),
        .pTRIG_PULSE_LEN (4)
    ) dut (
        .trace_clk      (clk),
        .resetn         (resetn),
        .match_hit      (match_hit),
        .pattern_enable (pattern_enable),
        .trig_enable    (trig_enable),
        .trig_toggle    (trig_toggle),
        .ts_clear       (ts_clear),
        .fifo_full      (fifo_full),
        .overflow_clear (overflow_clear),
`ifdef TRACE_TRIG_HOLDOFF_EN
        .trig_holdoff   (trig_holdoff),
`endif
        .fifo_wr_en     (fifo_wr_en),
        .fifo_wr_data   (fifo_wr_data),
        .trig_out       (trig_out),
        .pending        (pending),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (ts %0d)", name, act, exp, tb_ts);
        end
    endtask

    // One clock: track the expected timestamp, then pop the scoreboard on any FIFO write.
    task automatic tick();
        logic [63:0] exp;
        @(posedge clk);
        if (!resetn || ts_clear) tb_ts = '0;
        else                     tb_ts = tb_ts + 1'b1;
        @(negedge clk);
        if (resetn && fifo_wr_en) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL fifo_unexpected_write: got %h expected no write (ts %0d)", fifo_wr_data, tb_ts);
            end else begin
                exp = sb.pop_front();
                check("fifo_wr_data", fifo_wr_data, exp);
            end
        end
    endtask

    // Records for rules hit now, in the round-robin order they should leave (only used when idle).
    task automatic push_hits(input logic [7:0] v);
        int r;
        int last;
        last = -1;
        for (int k = 0; k < 8; k++) begin
            r = (tb_rr + k) % 8;
            if (v[r[2:0]]) begin
                sb.push_back({8'(r), tb_ts});
                last = r;
            end
        end
        if (last >= 0) tb_rr = (last + 1) % 8;
    endtask

    task automatic drain(input int n);
        repeat (n) tick();
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        check("pending_drained", 64'(pending), 64'd0);
    endtask

    task automatic wait_ts(input logic [55:0] target);
        for (int i = 0; i < 300 && tb_ts != target; i++) tick();
        if (tb_ts != target) begin
            tests++;
            fails++;
            $display("FAIL wait_ts: got %0d expected %0d", tb_ts, target);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{hit: 8'h01, en: 8'hFF, exp_pend: 8'h01};
        vecs[1] = '{hit: 8'h80, en: 8'hFF, exp_pend: 8'h80};
        vecs[2] = '{hit: 8'h81, en: 8'h7F, exp_pend: 8'h01};
        vecs[3] = '{hit: 8'hF0, en: 8'h0F, exp_pend: 8'h00};
        vecs[4] = '{hit: 8'h55, en: 8'hFF, exp_pend: 8'h55};
        vecs[5] = '{hit: 8'hAA, en: 8'hF0, exp_pend: 8'hA0};
        vecs[6] = '{hit: 8'hFF, en: 8'hFF, exp_pend: 8'hFF};
        vecs[7] = '{hit: 8'h24, en: 8'h24, exp_pend: 8'h24};

        resetn         = 1'b0;
        match_hit      = 8'hFF;
        pattern_enable = 8'hFF;
        trig_enable    = 1'b1;
        trig_toggle    = 1'b0;
        ts_clear       = 1'b0;
        fifo_full      = 1'b0;
        overflow_clear = 1'b0;
`ifdef TRACE_TRIG_HOLDOFF_EN
        trig_holdoff   = 16'd0;
`endif

        // Reset held two cycles with hits asserted
        tick();
        tick();
        check("rst_trig_out", 64'(trig_out), 64'd0);
        check("rst_fifo_wr_en", 64'(fifo_wr_en), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        resetn    = 1'b1;
        match_hit = 8'h00;
        check("rel_trig_out", 64'(trig_out), 64'd0);
        check("rel_overflow", 64'(overflow), 64'd0);
        // First hit after release must carry ts 0
        match_hit = 8'h20;
        push_hits(8'h20);
        tick();
        match_hit = 8'h00;
        drain(10);

        // Pulse mode: hit rule 3 at ts 100
        wait_ts(56'd100);
        for (int c = 0; c < 7; c++) begin
            match_hit = (c == 0) ? 8'h08 : 8'h00;
            if (c == 0) push_hits(8'h08);
            tick();
            check("pulse_trig_out", 64'(trig_out), 64'((c + 1 >= 1) && (c + 1 <= 4)));
            check("pulse_wr_en", 64'(fifo_wr_en), 64'(c + 1 == 2));
            if (c + 1 == 2) check("pulse_wr_data", fifo_wr_data, 64'h03_00000000000064);
        end
        match_hit = 8'h00;
        drain(4);

        // Bring the round-robin pointer to 0 via rule 7, then simultaneous hit at ts 10
        match_hit = 8'h80;
        push_hits(8'h80);
        tick();
        match_hit = 8'h00;
        drain(8);
        ts_clear = 1'b1;
        tick();
        ts_clear = 1'b0;
        wait_ts(56'd10);
        for (int c = 0; c < 7; c++) begin
            match_hit = (c == 0) ? 8'h81 : 8'h00;
            if (c == 0) push_hits(8'h81);
            tick();
            check("simul_trig_out", 64'(trig_out), 64'((c + 1 >= 1) && (c + 1 <= 4)));
            check("simul_wr_en", 64'(fifo_wr_en), 64'((c + 1 == 2) || (c + 1 == 3)));
            if (c + 1 == 2) check("simul_first", fifo_wr_data, 64'h00_0000000000000A);
            if (c + 1 == 3) check("simul_second", fifo_wr_data, 64'h07_0000000000000A);
        end
        match_hit = 8'h00;
        drain(4);

        // Table-driven single-cycle hit patterns with masking
        for (int i = 0; i < 8; i++) begin
            pattern_enable = vecs[i].en;
            match_hit      = vecs[i].hit;
            push_hits(vecs[i].exp_pend);
            tick();
            match_hit = 8'h00;
            check("vec_pending", 64'(pending), 64'(vecs[i].exp_pend));
            check("vec_trig_out", 64'(trig_out), 64'(vecs[i].exp_pend != 8'h00));
            drain(14);
        end
        pattern_enable = 8'hFF;

        // Backpressure: second hit on rule 2 is dropped, overflow is sticky
        fifo_full = 1'b1;
        match_hit = 8'h04;
        push_hits(8'h04);
        tick();
        tick();
        match_hit = 8'h00;
        check("bp_pending", 64'(pending), 64'h04);
        check("bp_overflow", 64'(overflow), 64'd1);
        match_hit      = 8'h04;
        overflow_clear = 1'b1;
        tick();
        match_hit = 8'h00;
        check("ovf_clear_vs_event", 64'(overflow), 64'd1);
        tick();
        overflow_clear = 1'b0;
        check("ovf_cleared", 64'(overflow), 64'd0);
        check("bp_hold", 64'(fifo_wr_en), 64'd0);
        fifo_full = 1'b0;
        drain(6);

        // Grant and re-hit of the same rule in one cycle
        match_hit = 8'h10;
        push_hits(8'h10);
        tick();
        push_hits(8'h10);
        tick();
        match_hit = 8'h00;
        check("rehit_pending", 64'(pending), 64'h10);
        check("rehit_overflow", 64'(overflow), 64'd0);
        drain(6);

        // A new hit during a pulse reloads the count
        for (int c = 0; c < 9; c++) begin
            match_hit = (c == 0) ? 8'h01 : ((c == 2) ? 8'h02 : 8'h00);
            if (match_hit != 8'h00) push_hits(match_hit);
            tick();
            check("reload_trig_out", 64'(trig_out), 64'((c + 1 >= 1) && (c + 1 <= 6)));
        end
        match_hit = 8'h00;
        drain(4);

        // trig_enable=0 blocks the trigger but logging continues
        trig_enable = 1'b0;
        match_hit   = 8'h01;
        push_hits(8'h01);
        for (int c = 0; c < 5; c++) begin
            tick();
            match_hit = 8'h00;
            check("disabled_trig_out", 64'(trig_out), 64'd0);
        end
        drain(4);
        trig_enable = 1'b1;

        // Toggle mode: hits at ts 20 and 25
        trig_toggle = 1'b1;
        tick();
        ts_clear = 1'b1;
        tick();
        ts_clear = 1'b0;
        wait_ts(56'd20);
        for (int c = 0; c < 8; c++) begin
            match_hit = (c == 0) ? 8'h02 : ((c == 5) ? 8'h40 : 8'h00);
            if (match_hit != 8'h00) push_hits(match_hit);
            tick();
            check("toggle_trig_out", 64'(trig_out), 64'((c + 1 >= 1) && (c + 1 <= 5)));
        end
        match_hit = 8'h0F;
        push_hits(8'h0F);
        tick();
        check("toggle_multi_hit", 64'(trig_out), 64'd1);
        match_hit   = 8'h00;
        trig_toggle = 1'b0;
        tick();
        check("toggle_mode_switch", 64'(trig_out), 64'd0);
        drain(10);

`ifdef TRACE_TRIG_HOLDOFF_EN
        // Holdoff of 10: hits at ts 0, 5, 12 trigger at 1 and 13 only
        trig_holdoff = 16'd10;
        ts_clear = 1'b1;
        tick();
        ts_clear = 1'b0;
        for (int c = 0; c < 18; c++) begin
            match_hit = (c == 0) ? 8'h01 : ((c == 5) ? 8'h02 : ((c == 12) ? 8'h04 : 8'h00));
            if (match_hit != 8'h00) push_hits(match_hit);
            tick();
            check("holdoff_trig_out", 64'(trig_out),
                  64'(((c + 1 >= 1) && (c + 1 <= 4)) || ((c + 1 >= 13) && (c + 1 <= 16))));
        end
        match_hit    = 8'h00;
        trig_holdoff = 16'd0;
        drain(4);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
